// File: rtl/wb_stage_pkg.sv
// Shared CPU types for the writeback path: register index, data word, and the
// writeback source select used by the arbiter.
package cpuDefine;
    localparam int DATA_WIDTH = 32;
    localparam int GR_WIDTH   = 5;
    localparam int rfNum      = 32;

    typedef logic [GR_WIDTH-1:0]   Gr;
    typedef logic [DATA_WIDTH-1:0] DType;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_BUF  = 2'd2,
        WB_LSU  = 2'd3
    } WbSrc;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy-register scoreboard: set on long-latency issue, clear on LSU-sourced commit, set wins a tie.
// Stall query is combinational; busy/count update one cycle after the request.
module wb_scoreboard
    import cpuDefine::*;
#(
    parameter int GR_W    = GR_WIDTH,
    parameter int REG_NUM = rfNum
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_set_vld,
    input  logic [GR_W-1:0] i_set_rd,
    input  logic            i_clr_vld,
    input  logic [GR_W-1:0] i_clr_rd,
    input  logic [GR_W-1:0] i_q_rj,
    input  logic [GR_W-1:0] i_q_rk,
    input  logic [GR_W-1:0] i_q_rd,
    output logic            o_issue_stall,
    output logic [GR_W:0]   o_pending_cnt
);

    logic [REG_NUM-1:0] r_busy;
    logic [GR_W:0]      r_cnt;
    logic               w_set;
    logic               w_same;
    logic               w_inc;
    logic               w_dec;

    // r0 is hardwired in the regfile, so it is never tracked.
    always_comb begin
        w_set  = i_set_vld && (i_set_rd != '0);
        w_same = w_set && i_clr_vld && (i_set_rd == i_clr_rd);
        w_inc  = w_set && !r_busy[i_set_rd];
        w_dec  = i_clr_vld && r_busy[i_clr_rd] && !w_same;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_clr_vld) begin
                r_busy[i_clr_rd] <= 1'b0;
            end
            // Applied after the clear so a same-register tie stays busy.
            if (w_set) begin
                r_busy[i_set_rd] <= 1'b1;
            end
            case ({w_inc, w_dec})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_issue_stall = r_busy[i_q_rj] | r_busy[i_q_rk] | r_busy[i_q_rd];
    assign o_pending_cnt = r_cnt;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU > skid buffer > direct LSU into one registered regfile write port, 1-cycle latency.
// ALU is never stalled; LSU sees lsu_ready=0 while the 1-entry skid buffer holds a result.
module wb_stage
    import cpuDefine::*;
#(
    parameter int DATA_W  = DATA_WIDTH,
    parameter int GR_W    = GR_WIDTH,
    parameter int REG_NUM = rfNum
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              alu_valid,
    input  logic              alu_we,
    input  logic [GR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [GR_W-1:0]   lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              iss_long_valid,
    input  logic [GR_W-1:0]   iss_long_rd,
    input  logic [GR_W-1:0]   q_rj,
    input  logic [GR_W-1:0]   q_rk,
    input  logic [GR_W-1:0]   q_rd,
    output logic              issue_stall,
    output logic              rf_we,
    output logic [GR_W-1:0]   rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [GR_W:0]     pending_cnt
);

    logic              r_buf_vld;
    logic [GR_W-1:0]   r_buf_rd;
    logic [DATA_W-1:0] r_buf_dat;
    logic              r_rf_we;
    logic [GR_W-1:0]   r_rf_rd;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_alu_win;
    logic              w_lsu_xfer;
    WbSrc              w_sel;
    logic [GR_W-1:0]   w_win_rd;
    logic [DATA_W-1:0] w_win_dat;
    logic              w_clr_vld;

    assign lsu_ready  = !r_buf_vld;
    assign w_alu_win  = alu_valid && alu_we;
    assign w_lsu_xfer = lsu_valid && lsu_ready;

    always_comb begin
        w_sel     = WB_NONE;
        w_win_rd  = r_rf_rd;
        w_win_dat = r_rf_wdata;
        if (w_alu_win) begin
            w_sel     = WB_ALU;
            w_win_rd  = alu_rd;
            w_win_dat = alu_data;
        end else if (r_buf_vld) begin
            w_sel     = WB_BUF;
            w_win_rd  = r_buf_rd;
            w_win_dat = r_buf_dat;
        end else if (w_lsu_xfer) begin
            w_sel     = WB_LSU;
            w_win_rd  = lsu_rd;
            w_win_dat = lsu_data;
        end
    end

    // A transfer can only happen with the buffer empty, so load and drain never collide.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_buf_vld <= 1'b0;
            r_buf_rd  <= '0;
            r_buf_dat <= '0;
        end else if (w_lsu_xfer && w_alu_win) begin
            r_buf_vld <= 1'b1;
            r_buf_rd  <= lsu_rd;
            r_buf_dat <= lsu_data;
        end else if (w_sel == WB_BUF) begin
            r_buf_vld <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we    <= (w_sel != WB_NONE);
            r_rf_rd    <= w_win_rd;
            r_rf_wdata <= w_win_dat;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;

    // Busy clears on the edge the LSU value enters rf_*; the regfile bypass covers the next read.
    assign w_clr_vld = (w_sel == WB_BUF) || (w_sel == WB_LSU);

    wb_scoreboard #(
        .GR_W    (GR_W),
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk           (aclk),
        .rst_n         (aresetn),
        .i_set_vld     (iss_long_valid),
        .i_set_rd      (iss_long_rd),
        .i_clr_vld     (w_clr_vld),
        .i_clr_rd      (w_win_rd),
        .i_q_rj        (q_rj),
        .i_q_rk        (q_rk),
        .i_q_rd        (q_rd),
        .o_issue_stall (issue_stall),
        .o_pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU path, collision/skid, scoreboard, set/clear race, async reset.
module tb_wb_stage;

    logic        aclk;
    logic        aresetn;
    logic        alu_valid;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_long_valid;
    logic [4:0]  iss_long_rd;
    logic [4:0]  q_rj;
    logic [4:0]  q_rk;
    logic [4:0]  q_rd;
    logic        issue_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [5:0]  pending_cnt;

    int n_checks = 0;
    int n_err    = 0;

    wb_stage dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .alu_valid      (alu_valid),
        .alu_we         (alu_we),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .iss_long_valid (iss_long_valid),
        .iss_long_rd    (iss_long_rd),
        .q_rj           (q_rj),
        .q_rk           (q_rk),
        .q_rd           (q_rd),
        .issue_stall    (issue_stall),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wdata       (rf_wdata),
        .pending_cnt    (pending_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_we         = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        lsu_valid      = 1'b0;
        lsu_rd         = '0;
        lsu_data       = '0;
        iss_long_valid = 1'b0;
        iss_long_rd    = '0;
        q_rj           = '0;
        q_rk           = '0;
        q_rd           = '0;
    endtask

    // Inputs set before tick() apply at the coming posedge; checks land 1ns after it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        aresetn        = 1'b0;
        alu_valid      = 1'($urandom);
        alu_we         = 1'b1;
        alu_rd         = 5'($urandom);
        alu_data       = $urandom;
        lsu_valid      = 1'b1;
        lsu_rd         = 5'($urandom);
        lsu_data       = $urandom;
        iss_long_valid = 1'b1;
        iss_long_rd    = 5'd6;
        q_rj           = 5'd6;
        q_rk           = '0;
        q_rd           = '0;
        repeat (3) tick();
        chk("rst_rf_we",    32'(rf_we), 32'd0);
        chk("rst_rf_rd",    32'(rf_rd), 32'd0);
        chk("rst_rf_wdata", rf_wdata,   32'd0);
        chk("rst_pending",  32'(pending_cnt), 32'd0);
        chk("rst_stall",    32'(issue_stall), 32'd0);
        idle();
        #2 aresetn = 1'b1;
        #1;
        chk("rel_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        chk("rel_rf_we", 32'(rf_we), 32'd0);

        // ---------------- ALU only ----------------
        alu_valid = 1'b1; alu_we = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        chk("alu_we",    32'(rf_we), 32'd1);
        chk("alu_rd",    32'(rf_rd), 32'd5);
        chk("alu_wdata", rf_wdata,   32'h1234);
        idle();
        tick();
        chk("alu_we_off",  32'(rf_we), 32'd0);
        chk("alu_rd_hold", 32'(rf_rd), 32'd5);
        chk("alu_dat_hold", rf_wdata,  32'h1234);

        // ALU with we=0 is not a write
        alu_valid = 1'b1; alu_we = 1'b0; alu_rd = 5'd6; alu_data = 32'h77;
        tick();
        chk("alu_nowe", 32'(rf_we), 32'd0);
        idle();

        // ---------------- collision ----------------
        iss_long_valid = 1'b1; iss_long_rd = 5'd7;
        tick();
        chk("col_pend1", 32'(pending_cnt), 32'd1);
        idle();
        alu_valid = 1'b1; alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hBB;
        #1;
        chk("col_ready_pre", 32'(lsu_ready), 32'd1);
        tick();
        chk("col_c1_we",    32'(rf_we), 32'd1);
        chk("col_c1_rd",    32'(rf_rd), 32'd3);
        chk("col_c1_dat",   rf_wdata,   32'hAA);
        chk("col_c1_ready", 32'(lsu_ready), 32'd0);
        chk("col_c1_pend",  32'(pending_cnt), 32'd1);
        idle();
        tick();
        chk("col_c2_we",   32'(rf_we), 32'd1);
        chk("col_c2_rd",   32'(rf_rd), 32'd7);
        chk("col_c2_dat",  rf_wdata,   32'hBB);
        chk("col_c2_pend", 32'(pending_cnt), 32'd0);
        tick();
        chk("col_c3_ready", 32'(lsu_ready), 32'd1);
        chk("col_c3_we",    32'(rf_we), 32'd0);

        // ---------------- buffer held behind back-to-back ALU writes ----------------
        iss_long_valid = 1'b1; iss_long_rd = 5'd8;
        tick();
        idle();
        alu_valid = 1'b1; alu_we = 1'b1; alu_rd = 5'd10; alu_data = 32'hC1;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        tick();
        chk("hold_c1_rd", 32'(rf_rd), 32'd10);
        lsu_valid = 1'b0;
        alu_rd = 5'd11; alu_data = 32'hC2;
        #1;
        chk("hold_ready", 32'(lsu_ready), 32'd0);
        tick();
        chk("hold_c2_rd",  32'(rf_rd), 32'd11);
        chk("hold_c2_dat", rf_wdata,   32'hC2);
        idle();
        tick();
        chk("hold_c3_rd",   32'(rf_rd), 32'd8);
        chk("hold_c3_dat",  rf_wdata,   32'h88);
        chk("hold_c3_pend", 32'(pending_cnt), 32'd0);
        tick();

        // ---------------- scoreboard stall / release ----------------
        iss_long_valid = 1'b1; iss_long_rd = 5'd9;
        tick();
        idle();
        chk("sb_pend1", 32'(pending_cnt), 32'd1);
        q_rj = 5'd9;
        #1;
        chk("sb_stall_rj", 32'(issue_stall), 32'd1);
        q_rj = 5'd0; q_rk = 5'd9;
        #1;
        chk("sb_stall_rk", 32'(issue_stall), 32'd1);
        q_rk = 5'd1;
        #1;
        chk("sb_nostall", 32'(issue_stall), 32'd0);
        q_rj = 5'd9;
        tick();
        chk("sb_stall_hold", 32'(issue_stall), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        #1;
        chk("sb_stall_pre", 32'(issue_stall), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("sb_we",    32'(rf_we), 32'd1);
        chk("sb_rd",    32'(rf_rd), 32'd9);
        chk("sb_dat",   rf_wdata,   32'h99);
        chk("sb_stall", 32'(issue_stall), 32'd0);
        chk("sb_pend0", 32'(pending_cnt), 32'd0);
        idle();

        // ---------------- r0: presented, never busy ----------------
        alu_valid = 1'b1; alu_we = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        iss_long_valid = 1'b1; iss_long_rd = 5'd0;
        tick();
        idle();
        chk("r0_we",    32'(rf_we), 32'd1);
        chk("r0_rd",    32'(rf_rd), 32'd0);
        chk("r0_dat",   rf_wdata,   32'h55);
        chk("r0_pend",  32'(pending_cnt), 32'd0);
        chk("r0_stall", 32'(issue_stall), 32'd0);

        // ---------------- set/clear race on r4 ----------------
        iss_long_valid = 1'b1; iss_long_rd = 5'd4;
        tick();
        idle();
        chk("race_pend_pre", 32'(pending_cnt), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        iss_long_valid = 1'b1; iss_long_rd = 5'd4;
        tick();
        idle();
        chk("race_we",   32'(rf_we), 32'd1);
        chk("race_rd",   32'(rf_rd), 32'd4);
        chk("race_pend", 32'(pending_cnt), 32'd1);
        q_rd = 5'd4;
        #1;
        chk("race_busy", 32'(issue_stall), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h45;
        tick();
        idle();
        chk("race_clr_pend", 32'(pending_cnt), 32'd0);

        // ---------------- async reset with full buffer ----------------
        iss_long_valid = 1'b1; iss_long_rd = 5'd2;
        tick();
        idle();
        alu_valid = 1'b1; alu_we = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        tick();
        idle();
        q_rj = 5'd2;
        #1;
        chk("ar_pre_ready", 32'(lsu_ready), 32'd0);
        chk("ar_pre_stall", 32'(issue_stall), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("ar_ready",  32'(lsu_ready), 32'd1);
        chk("ar_pend",   32'(pending_cnt), 32'd0);
        chk("ar_stall",  32'(issue_stall), 32'd0);
        chk("ar_we",     32'(rf_we), 32'd0);
        chk("ar_rd",     32'(rf_rd), 32'd0);
        chk("ar_wdata",  rf_wdata,   32'd0);
        #1 aresetn = 1'b1;
        tick();
        chk("ar_post_we1", 32'(rf_we), 32'd0);
        tick();
        chk("ar_post_we2", 32'(rf_we), 32'd0);
        chk("ar_post_pend", 32'(pending_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
